// File: rtl/sar_r2r_adc_pkg.sv
// Shared types and default sizing for the SAR R2R ADC controller.
package sar_r2r_adc_pkg;

    localparam int unsigned SAR_WIDTH     = 8;
    localparam int unsigned SAR_SETTLE    = 100;
    localparam int unsigned SAR_SYNC      = 2;
    localparam int unsigned SAR_AVG_SHIFT = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DECIDE = 2'd2,
        DONE   = 2'd3
    } sar_state_t;

endpackage

// File: rtl/sar_r2r_adc_if.sv
// Control, comparator and result bundle between the SAR controller and its user.
interface sar_r2r_adc_if #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned AVG_SHIFT = 4
);
    logic                        enable;
    logic                        comp_in;
    logic [WIDTH-1:0]            r2r_out;
    logic                        busy;
    logic [WIDTH-1:0]            data;
    logic                        data_valid;
    logic [WIDTH+AVG_SHIFT-1:0]  ave_data;
    logic                        ave_valid;

    modport master (
        output enable, comp_in,
        input  r2r_out, busy, data, data_valid, ave_data, ave_valid
    );

    modport slave (
        input  enable, comp_in,
        output r2r_out, busy, data, data_valid, ave_data, ave_valid
    );
endinterface

// File: rtl/sar_r2r_adc_sync.sv
// Multi-flop synchronizer for a single asynchronous bit, reset to 0.
module bit_synchronizer #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) ff <= '0;
        else       ff <= (ff << 1) | STAGES'(d);
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/sar_r2r_adc.sv
// SAR controller: walks R2R trial codes one bit per settle window, publishes
// each result and a running 2^AVG_SHIFT-sample sum.
module sar_r2r_adc
    import sar_r2r_adc_pkg::*;
#(
    parameter int unsigned WIDTH         = SAR_WIDTH,
    parameter int unsigned SETTLE_CYCLES = SAR_SETTLE,
    parameter int unsigned SYNC_STAGES   = SAR_SYNC,
    parameter int unsigned AVG_SHIFT     = SAR_AVG_SHIFT
) (
    input  logic               clk,
    input  logic               reset,
    sar_r2r_adc_if.slave       bus
);

    localparam int unsigned IDX_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam int unsigned CNT_W = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int unsigned ACC_W = WIDTH + AVG_SHIFT;
    localparam int unsigned N_W   = AVG_SHIFT;

    localparam logic [1:0] S_IDLE   = 2'(IDLE);
    localparam logic [1:0] S_SETTLE = 2'(SETTLE);
    localparam logic [1:0] S_DECIDE = 2'(DECIDE);
    localparam logic [1:0] S_DONE   = 2'(DONE);

    logic             comp_s;
    logic [1:0]       state,   state_n;
    logic [CNT_W-1:0] cnt,     cnt_n;
    logic [IDX_W-1:0] bit_idx, idx_n;
    logic [WIDTH-1:0] result,  result_n;
    logic [WIDTH-1:0] r2r,     r2r_n;
    logic             busy_q,  busy_n;
    logic [WIDTH-1:0] data_q,  data_n;
    logic             dv_q,    dv_n;
    logic [ACC_W-1:0] acc,     acc_n;
    logic [N_W-1:0]   n,       n_n;
    logic [ACC_W-1:0] ave_q,   ave_n;
    logic             av_q,    av_n;
    logic [WIDTH-1:0] res_bit;

    bit_synchronizer #(.STAGES(SYNC_STAGES)) u_comp_sync (
        .clk   (clk),
        .reset (reset),
        .d     (bus.comp_in),
        .q     (comp_s)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            result  <= '0;
            r2r     <= '0;
            busy_q  <= 1'b0;
            data_q  <= '0;
            dv_q    <= 1'b0;
            acc     <= '0;
            n       <= '0;
            ave_q   <= '0;
            av_q    <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= idx_n;
            result  <= result_n;
            r2r     <= r2r_n;
            busy_q  <= busy_n;
            data_q  <= data_n;
            dv_q    <= dv_n;
            acc     <= acc_n;
            n       <= n_n;
            ave_q   <= ave_n;
            av_q    <= av_n;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        idx_n    = bit_idx;
        result_n = result;
        r2r_n    = r2r;
        busy_n   = busy_q;
        data_n   = data_q;
        dv_n     = 1'b0;
        acc_n    = acc;
        n_n      = n;
        ave_n    = ave_q;
        av_n     = 1'b0;
        res_bit  = result;

        case (state)
            S_IDLE: begin
                if (bus.enable) begin
                    state_n  = S_SETTLE;
                    idx_n    = IDX_W'(WIDTH - 1);
                    result_n = '0;
                    r2r_n    = WIDTH'(1) << (WIDTH - 1);
                    cnt_n    = '0;
                    busy_n   = 1'b1;
                end
            end
            S_SETTLE: begin
                cnt_n = cnt + CNT_W'(1);
                if (cnt == CNT_W'(SETTLE_CYCLES - 1)) state_n = S_DECIDE;
            end
            S_DECIDE: begin
                // Trial bit survives only if the input is at or above the DAC level.
                res_bit[bit_idx] = comp_s;
                result_n         = res_bit;
                if (bit_idx != '0) begin
                    idx_n   = bit_idx - IDX_W'(1);
                    r2r_n   = res_bit | (WIDTH'(1) << idx_n);
                    cnt_n   = '0;
                    state_n = S_SETTLE;
                end else begin
                    data_n  = res_bit;
                    dv_n    = 1'b1;
                    r2r_n   = res_bit;
                    state_n = S_DONE;
                end
            end
            S_DONE: begin
                busy_n  = 1'b0;
                state_n = S_IDLE;
                if (n == {N_W{1'b1}}) begin
                    ave_n = acc + ACC_W'(data_q);
                    av_n  = 1'b1;
                    acc_n = '0;
                    n_n   = '0;
                end else begin
                    acc_n = acc + ACC_W'(data_q);
                    n_n   = n + N_W'(1);
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign bus.r2r_out    = r2r;
    assign bus.busy       = busy_q;
    assign bus.data       = data_q;
    assign bus.data_valid = dv_q;
    assign bus.ave_data   = ave_q;
    assign bus.ave_valid  = av_q;

endmodule
